// File: rtl/pipe_tag_pkg.sv
// Shared types and the lane-merge helper for the pipelined-cache tag store.
package pipe_tag_pkg;

  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_e;

  // Widest word / mask the merge helper handles; instantiations stay within these.
  localparam int MERGE_W  = 64;
  localparam int MASK_MAX = 16;

  // Replace every lane of old_w whose mask bit is set with the same lane of new_w.
  // Shared by the write path and the write-to-read bypass so both agree bit for bit.
  function automatic logic [MERGE_W-1:0] merge_lanes(input logic [MERGE_W-1:0]  old_w,
                                                     input logic [MERGE_W-1:0]  new_w,
                                                     input logic [MASK_MAX-1:0] mask,
                                                     input int                  lane_w);
    logic [MERGE_W-1:0] r;
    int lane;
    r = old_w;
    for (int b = 0; b < MERGE_W; b++) begin
      lane = b / lane_w;
      if (lane < MASK_MAX) begin
        if (mask[lane[3:0]]) r[b] = new_w[b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_tag_valid.sv
// Per-entry valid flops. Kept apart from the data array so the data can later
// move onto a RAM macro while valids stay in flops for single-cycle clear.
module pipe_tag_valid #(
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  sweep_clr,
  input  logic [ADDR_WIDTH-1:0] sweep_idx,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  output logic [RAM_DEPTH-1:0]  vld
);

  // Sweep owns the array; otherwise clear is applied after set so it wins on a tie.
  always_ff @(posedge clk) begin
    if (sweep_clr) begin
      vld[sweep_idx] <= 1'b0;
    end else begin
      if (set_en) vld[set_idx] <= 1'b1;
      if (clr_en) vld[clr_idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_tag_array.sv
// 1W/1R tag store with valid bits, masked writes, invalidate, write-to-read
// bypass and an init/flush sweep that zeroes every entry.
module pipe_tag_array
  import pipe_tag_pkg::*;
#(
  parameter int DATA_WIDTH = 23,
  parameter int ADDR_WIDTH = 4,
  parameter int MASK_WIDTH = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  output logic                  ready,
  input  logic                  csb0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [MASK_WIDTH-1:0] wmask0,
  input  logic                  inv_en,
  input  logic [ADDR_WIDTH-1:0] inv_addr,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  vout1
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LANE_W    = DATA_WIDTH / MASK_WIDTH;

  state_e                state;
  logic [ADDR_WIDTH:0]   sweep_idx;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_DEPTH-1:0]  vld;

  logic                  idle, sweep_we, wr_en, inv_go, rd_en, rd_hit;
  logic [DATA_WIDTH-1:0] wr_word, rd_word;
  logic                  rd_vld;

  assign idle     = (state == ST_IDLE);
  assign sweep_we = (state == ST_INIT) && !rst;
  assign wr_en    = idle && !csb0 && (|wmask0);
  assign inv_go   = idle && inv_en;
  assign rd_en    = idle && !csb1;
  assign rd_hit   = wr_en && (addr0 == addr1);

  // Merged write word: old entry with the enabled lanes replaced by din0.
  always_comb begin
    wr_word = DATA_WIDTH'(merge_lanes(MERGE_W'(mem[addr0]), MERGE_W'(din0),
                                      MASK_MAX'(wmask0), LANE_W));
  end

  // Read-side view of the entry, optionally including this cycle's write/invalidate.
  always_comb begin
    rd_word = mem[addr1];
    rd_vld  = vld[addr1];
    if (BYPASS != 0) begin
      if (rd_hit) begin
        rd_word = wr_word;
        rd_vld  = 1'b1;
      end
      if (inv_go && (inv_addr == addr1)) rd_vld = 1'b0;
    end
  end

  // Data array: the sweep zeroes one entry per cycle, otherwise masked writes.
  always_ff @(posedge clk) begin
    if (sweep_we)   mem[sweep_idx[ADDR_WIDTH-1:0]] <= '0;
    else if (wr_en) mem[addr0] <= wr_word;
  end

  pipe_tag_valid #(.ADDR_WIDTH(ADDR_WIDTH), .RAM_DEPTH(RAM_DEPTH)) u_valid (
    .clk       (clk),
    .sweep_clr (sweep_we),
    .sweep_idx (sweep_idx[ADDR_WIDTH-1:0]),
    .set_en    (wr_en),
    .set_idx   (addr0),
    .clr_en    (inv_go),
    .clr_idx   (inv_addr),
    .vld       (vld)
  );

  // Sweep FSM plus registered read port; reads hold while sweeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
      ready     <= 1'b0;
      dout1     <= '0;
      vout1     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_idx <= sweep_idx + 1'b1;
          if (sweep_idx == (ADDR_WIDTH+1)'(RAM_DEPTH - 1)) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          if (rd_en) begin
            dout1 <= rd_word;
            vout1 <= rd_vld;
          end
          if (flush_req) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
            ready     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_tag_array.sv
// Directed scoreboard bench: two instances (default 23b/1-lane/bypass and
// 24b/2-lane/no-bypass); expected read responses are queued at issue time.
module tb_pipe_tag_array;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // default instance
  logic        flush_req, ready, csb0, wmask0, inv_en, csb1, vout1;
  logic [3:0]  addr0, inv_addr, addr1;
  logic [22:0] din0, dout1;
  // masked / no-bypass instance
  logic        m_flush_req, m_ready, m_csb0, m_inv_en, m_csb1, m_vout1;
  logic [1:0]  m_wmask0;
  logic [3:0]  m_addr0, m_inv_addr, m_addr1;
  logic [23:0] m_din0, m_dout1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [24:0] q_a[$];
  logic [24:0] q_m[$];

  pipe_tag_array u_dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .ready(ready),
    .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
    .inv_en(inv_en), .inv_addr(inv_addr),
    .csb1(csb1), .addr1(addr1), .dout1(dout1), .vout1(vout1)
  );

  pipe_tag_array #(.DATA_WIDTH(24), .ADDR_WIDTH(4), .MASK_WIDTH(2), .BYPASS(0)) u_dut_m (
    .clk(clk), .rst(rst), .flush_req(m_flush_req), .ready(m_ready),
    .csb0(m_csb0), .addr0(m_addr0), .din0(m_din0), .wmask0(m_wmask0),
    .inv_en(m_inv_en), .inv_addr(m_inv_addr),
    .csb1(m_csb1), .addr1(m_addr1), .dout1(m_dout1), .vout1(m_vout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // advance one cycle, then drop all single-cycle strobes
  task automatic step();
    @(posedge clk); #1;
    csb0 = 1'b1; csb1 = 1'b1; inv_en = 1'b0; flush_req = 1'b0;
    m_csb0 = 1'b1; m_csb1 = 1'b1; m_inv_en = 1'b0; m_flush_req = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [22:0] d);
    csb0 = 1'b0; addr0 = a; din0 = d; wmask0 = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [22:0] d, input logic v);
    csb1 = 1'b0; addr1 = a;
    q_a.push_back({v, 1'b0, d});
  endtask

  task automatic m_wr(input logic [3:0] a, input logic [23:0] d, input logic [1:0] m);
    m_csb0 = 1'b0; m_addr0 = a; m_din0 = d; m_wmask0 = m;
  endtask

  task automatic m_rd(input logic [3:0] a, input logic [23:0] d, input logic v);
    m_csb1 = 1'b0; m_addr1 = a;
    q_m.push_back({v, d});
  endtask

  // monitors: a read sampled at an edge is checked at the following negedge
  always @(posedge clk) begin
    if (csb1 === 1'b0) begin
      logic [24:0] e;
      @(negedge clk);
      if (q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_a_unexpected: got %0h with no expected entry", dout1);
      end else begin
        e = q_a.pop_front();
        chk("rd_a_data", 32'(dout1), 32'(e[22:0]));
        chk("rd_a_vld",  32'(vout1), 32'(e[24]));
      end
    end
  end

  always @(posedge clk) begin
    if (m_csb1 === 1'b0) begin
      logic [24:0] e;
      @(negedge clk);
      if (q_m.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_m_unexpected: got %0h with no expected entry", m_dout1);
      end else begin
        e = q_m.pop_front();
        chk("rd_m_data", 32'(m_dout1), 32'(e[23:0]));
        chk("rd_m_vld",  32'(m_vout1), 32'(e[24]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush_req = 1'b0; csb0 = 1'b1; addr0 = '0; din0 = '0; wmask0 = 1'b0;
    inv_en = 1'b0; inv_addr = '0; csb1 = 1'b1; addr1 = '0;
    m_flush_req = 1'b0; m_csb0 = 1'b1; m_addr0 = '0; m_din0 = '0; m_wmask0 = '0;
    m_inv_en = 1'b0; m_inv_addr = '0; m_csb1 = 1'b1; m_addr1 = '0;

    // reset state
    step(); step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_dout1", 32'(dout1), 32'd0);
    chk("rst_vout1", 32'(vout1), 32'd0);
    chk("rst_m_ready", 32'(m_ready), 32'd0);

    // init sweep: ready rises after exactly 16 edges
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("init_ready_%0d", k), 32'(ready), (k == 16) ? 32'd1 : 32'd0);
    end
    chk("init_m_ready", 32'(m_ready), 32'd1);

    // every entry swept to zero / invalid
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 23'h0, 1'b0); step();
    end

    // plain write then read
    wr(4'd3, 23'h12345); step();
    rd(4'd3, 23'h12345, 1'b1); step();

    // same-cycle write/read bypass
    wr(4'd7, 23'h7F); rd(4'd7, 23'h7F, 1'b1); step();

    // write + invalidate same index: data lands, valid cleared
    wr(4'd2, 23'h1); inv_en = 1'b1; inv_addr = 4'd2; step();
    rd(4'd2, 23'h1, 1'b0); step();
    // invalidate alone keeps data
    inv_en = 1'b1; inv_addr = 4'd3; step();
    rd(4'd3, 23'h12345, 1'b0); step();
    // read + invalidate same index with bypass: old data, valid 0
    wr(4'd4, 23'h55); step();
    rd(4'd4, 23'h55, 1'b0); inv_en = 1'b1; inv_addr = 4'd4; step();
    rd(4'd4, 23'h55, 1'b0); step();

    // masked-lane instance (lane 0 = bits 11:0), no bypass
    m_wr(4'd5, 24'hAAAAAA, 2'b11); step();
    m_wr(4'd5, 24'h555555, 2'b01); step();
    m_rd(4'd5, 24'hAAA555, 1'b1); step();
    m_wr(4'd6, 24'hFFFFFF, 2'b00); step();
    m_rd(4'd6, 24'h000000, 1'b0); step();
    m_wr(4'd7, 24'h00007F, 2'b11); m_rd(4'd7, 24'h000000, 1'b0); step();
    m_rd(4'd7, 24'h00007F, 1'b1); step();

    // fill all entries, then flush; the read alongside flush_req is still served
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 23'h100 + 23'(i)); step();
    end
    flush_req = 1'b1; rd(4'd9, 23'h109, 1'b1); step();
    chk("flush_ready_0", 32'(ready), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) rd(4'd1, 23'h109, 1'b1);   // ignored: output holds
      step();
      chk($sformatf("flush_ready_%0d", k), 32'(ready), (k == 16) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 23'h0, 1'b0); step();
    end

    // reset in the middle of a sweep restarts it
    wr(4'd5, 23'h3); step();
    flush_req = 1'b1; step();
    repeat (7) step();
    rst = 1'b1; step();
    chk("midrst_dout1", 32'(dout1), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("midrst_ready_%0d", k), 32'(ready), (k == 16) ? 32'd1 : 32'd0);
    end
    rd(4'd5, 23'h0, 1'b0); step();

    repeat (3) step();
    chk("drain_a", 32'(q_a.size()), 32'd0);
    chk("drain_m", 32'(q_m.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
